core_gpr_wb: RTL

- Writeback initiator for the GPR file.
- Merges ALU results and LSU load results onto the single GPR write port (wb/wb_addr/wb_data).
- Buffers loads in a small queue and tracks pending destinations in a 16-entry scoreboard for the issue stage.
- Sits between the execute/LSU stages and core_rf_gpr.

---
 rtl/i2d_core_pkg.sv | 30 +++
 rtl/core_wb_fifo.sv | 71 +++++++
 rtl/core_gpr_wb.sv | 120 ++++++++++++
 3 files changed

// File: rtl/i2d_core_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : i2d_core_pkg
//  Description : Shared GPR widths, types and helpers for the writeback path.
//  Revision    : 1.0 - initial release
// ============================================================================
package i2d_core_pkg;

    localparam int GPR_AW = 4;
    localparam int GPR_DW = 32;
    localparam int NGPR   = 16;

    typedef logic [GPR_AW-1:0] gpr_addr_t;
    typedef logic [GPR_DW-1:0] gpr_data_t;

    typedef struct packed {
        gpr_addr_t addr;
        gpr_data_t data;
    } wb_req_t;

    // One-hot decode of a GPR index into a per-register bit vector.
    function automatic logic [NGPR-1:0] gpr_onehot(input gpr_addr_t addr);
        logic [NGPR-1:0] v;
        v       = '0;
        v[addr] = 1'b1;
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/core_wb_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : core_wb_fifo
//  Description : Synchronous FIFO of writeback requests (load queue).
//                No bypass: a push becomes visible at the head one edge later.
//  Revision    : 1.0 - initial release
// ============================================================================
module core_wb_fifo
    import i2d_core_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    push,
    input  wb_req_t push_data,
    input  logic    pop,
    output wb_req_t pop_data,
    output logic    full,
    output logic    empty
);

    localparam int unsigned   c_AW       = $clog2(DEPTH);
    localparam logic [c_AW:0] c_FULL_CNT = (c_AW+1)'(DEPTH);

    wb_req_t           r_mem [DEPTH];
    logic [c_AW-1:0]   r_wr_ptr;
    logic [c_AW-1:0]   r_rd_ptr;
    logic [c_AW:0]     r_count;

    logic              w_do_push;
    logic              w_do_pop;

    // Push while full is only accepted alongside a pop; pop needs stored data.
    assign w_do_pop  = pop  & (r_count != '0);
    assign w_do_push = push & ((r_count != c_FULL_CNT) | w_do_pop);

    assign full     = (r_count == c_FULL_CNT);
    assign empty    = (r_count == '0);
    assign pop_data = r_mem[r_rd_ptr];

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/core_gpr_wb.sv
`default_nettype none
// ============================================================================
//  Module      : core_gpr_wb
//  Description : GPR writeback initiator. Merges ALU results (fixed priority)
//                and queued LSU loads onto the single GPR write port, and
//                keeps a pending-write scoreboard for the issue stage.
//                Optional macro I2D_WB_BYPASS_EN adds two forwarding read
//                ports and hides the committing register from sb_busy.
//  Revision    : 1.0 - initial release
// ============================================================================
module core_gpr_wb
    import i2d_core_pkg::*;
#(
    parameter int LQ_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        iss_valid,
    input  logic [3:0]  iss_addr,
    input  logic        alu_valid,
    input  logic [3:0]  alu_addr,
    input  logic [31:0] alu_data,
    input  logic        lsu_valid,
    output logic        lsu_ready,
    input  logic [3:0]  lsu_addr,
    input  logic [31:0] lsu_data,
    output logic        wb,
    output logic [3:0]  wb_addr,
    output logic [31:0] wb_data,
`ifdef I2D_WB_BYPASS_EN
    input  logic [3:0]  byp_a_addr,
    input  logic [3:0]  byp_b_addr,
    input  logic [31:0] rf_a_data,
    input  logic [31:0] rf_b_data,
    output logic [31:0] byp_a_data,
    output logic [31:0] byp_b_data,
`endif
    output logic [15:0] sb_busy
);

    wb_req_t         w_lq_head;
    wb_req_t         w_lq_in;
    logic            w_lq_full;
    logic            w_lq_empty;
    logic            w_push;
    logic            w_pop;
    logic [NGPR-1:0] w_sb_set;
    logic [NGPR-1:0] w_sb_clr;

    logic            r_wb;
    gpr_addr_t       r_wb_addr;
    gpr_data_t       r_wb_data;
    logic [NGPR-1:0] r_sb;

    assign lsu_ready    = rst_n & ~w_lq_full;
    assign w_push       = lsu_valid & lsu_ready;
    // Loads only drain on cycles the ALU leaves the write port free.
    assign w_pop        = ~alu_valid & ~w_lq_empty;
    assign w_lq_in.addr = lsu_addr;
    assign w_lq_in.data = lsu_data;

    core_wb_fifo #(
        .DEPTH     (LQ_DEPTH)
    ) u_lq (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (w_push),
        .push_data (w_lq_in),
        .pop       (w_pop),
        .pop_data  (w_lq_head),
        .full      (w_lq_full),
        .empty     (w_lq_empty)
    );

    // Write-port register: ALU first, then queue head; address/data hold when idle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wb      <= 1'b0;
            r_wb_addr <= '0;
            r_wb_data <= '0;
        end else if (alu_valid) begin
            r_wb      <= 1'b1;
            r_wb_addr <= alu_addr;
            r_wb_data <= alu_data;
        end else if (w_pop) begin
            r_wb      <= 1'b1;
            r_wb_addr <= w_lq_head.addr;
            r_wb_data <= w_lq_head.data;
        end else begin
            r_wb      <= 1'b0;
        end
    end

    assign w_sb_set = iss_valid ? gpr_onehot(iss_addr)  : '0;
    assign w_sb_clr = r_wb      ? gpr_onehot(r_wb_addr) : '0;

    // Scoreboard: clear on commit, then set; a same-edge set of the same bit wins.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sb <= '0;
        end else begin
            r_sb <= (r_sb & ~w_sb_clr) | w_sb_set;
        end
    end

    assign wb      = r_wb;
    assign wb_addr = r_wb_addr;
    assign wb_data = r_wb_data;

`ifdef I2D_WB_BYPASS_EN
    // The committing register is forwarded, so it no longer blocks issue.
    assign sb_busy    = r_sb & ~w_sb_clr;
    assign byp_a_data = (r_wb && (r_wb_addr == byp_a_addr)) ? r_wb_data : rf_a_data;
    assign byp_b_data = (r_wb && (r_wb_addr == byp_b_addr)) ? r_wb_data : rf_b_data;
`else
    assign sb_busy    = r_sb;
`endif

endmodule
`default_nettype wire
